adc_stim_model: RTL and testbench
=================================

# adc_stim_model

Parametrised, clocked behavioural model of the off-chip ADC front end for the SoC top-level bench. It replaces hand-written one-shot `adc_eoc_n`/`adc_data` stimulus. It supports:
- multiple channels, each with a per-channel sample queue loaded by the bench;
- a programmable conversion latency;
- single-shot or continuous round-robin scan modes.

It sits beside the DUT and is wired to the DUT's `adc_*` and `dac_reg` pins.

## Interface
- `NUM_CH`, 4, number of ADC channels (≥1)
- `DATA_WIDTH`, 8, sample width (≥2)
- `CONV_CYCLES`, 730, clocks from trigger to end-of-conversion (≥1)
- `SAMPLE_DEPTH`, 8, per-channel sample queue depth (power of two, ≥2)
- `clk  in  1  model clock (connected to DUT adc_clk)`
- `rst  in  1  asynchronous, active-high reset`
- `adc_en  in  1  enable; low aborts any conversion`
- `start  in  1  conversion trigger, rising-edge sensitive (e.g. dac_reg[0])`
- `cont  in  1  1 = continuous scan mode, 0 = single-shot`
- `ch_sel  in  CH_W  start channel; CH_W = NUM_CH>1 ? $clog2(NUM_CH) : 1`
- `load_valid  in  1  push load_data into queue load_ch`
- `load_ch  in  CH_W  target channel for load`
- `load_data  in  DATA_WIDTH  sample to enqueue`
- `adc_eoc_n  out  1  end-of-conversion strobe, active low, one cycle`
- `adc_data  out  DATA_WIDTH  result, valid only while adc_eoc_n = 0`
- `adc_ch  out  CH_W  channel of the current/last result`
- `busy  out  1  conversion in progress`
- `overrun  out  1  sticky: trigger arrived while busy`
- `overflow  out  1  sticky: load dropped on a full queue`
- `conv_cnt  out  16  completed conversions, wraps at 2^16`

## Operation
- FSM states:
  - IDLE → CONV on a rising edge of `start` (start=1 this edge, 0 previous edge) with `adc_en`=1. Latches `ch_sel` into `adc_ch` and loads the down-counter with `CONV_CYCLES-1`.
  - CONV → EOC when the counter reaches 0.
  - EOC → IDLE when `cont`=0.
  - EOC → CONV when `cont`=1. `adc_ch` advances by 1 modulo `NUM_CH` and the counter reloads.
- `adc_en`=0 in any state forces IDLE next edge. The counter clears, there is no strobe and no pop.
- EOC cycle:
  - `adc_eoc_n`=0.
  - If queue `adc_ch` is non-empty, `adc_data` is its head entry and the entry is popped.
  - Otherwise `adc_data` is the default pattern, which alternates per empty conversion: first 0101…01 (0x55 at width 8), then its complement (0xAA). The toggle is global, not per channel.
  - `conv_cnt` increments.
- A rising `start` edge while in CONV or EOC is ignored and sets `overrun`.
- Queues are circular buffers with separate read/write pointers plus a count.
  - Load into a full queue is dropped and sets `overflow`.
  - Load and pop on the same channel in the same cycle: if the queue is full, both take effect. If the queue is empty, the load is stored and the pop returns the default pattern (no bypass).
- `overrun` and `overflow` clear only on `rst`.

## Timing
- Reset values:
  - `adc_eoc_n`=1, `adc_data`=0, `adc_ch`=0, `busy`=0, `overrun`=0, `overflow`=0, `conv_cnt`=0.
  - Queues empty; default-pattern toggle at 0101… phase; FSM in IDLE.
- All outputs are registered.
- Latency: trigger edge detected at clock edge t0. Then `busy` goes to 1 at t0+1, and `adc_eoc_n` falls at t0+CONV_CYCLES and rises at t0+CONV_CYCLES+1.
- In continuous mode, successive strobes are CONV_CYCLES+1 clocks apart.
- `busy`=1 throughout CONV and EOC.
- An asserted `rst` mid-conversion returns all outputs to reset values immediately, independent of the clock. The edge detector's previous-`start` register resets to 1, so a `start` held high through reset does not trigger.
- A load is visible to a pop no earlier than the edge after the one that stores it.

## Configuration
- `ADC_STIM_XPROP_EN` defined: `adc_data` is driven all-X whenever `adc_eoc_n`=1, so the DUT is caught sampling the data outside the strobe.
- Not defined: `adc_data` is driven 0 outside the strobe. The model is then fully 2-state and usable in cycle-based simulation.

## Test plan
- NUM_CH=4, CONV_CYCLES=730, no loads, ch_sel=2, single `start` pulse at edge t0 → `adc_eoc_n`=0 only during cycle t0+730; `adc_data`=0x55; `adc_ch`=2; `conv_cnt`=1. A second pulse → 0xAA.
- Load 0x11, 0x22 into channel 1; trigger twice on channel 1 → results 0x11 then 0x22. A third trigger → default pattern 0x55.
- `cont`=1, CONV_CYCLES=4, ch_sel=3, NUM_CH=4 → strobes every 5 clocks with `adc_ch` sequence 3,0,1,2,3. Drop `adc_en` → no further strobe, `busy`=0 next edge.
- `start` edge while `busy` → `overrun`=1, no extra strobe, original strobe timing unchanged.
- SAMPLE_DEPTH=2: load 3 samples to channel 0 → `overflow`=1, first two retained. With the queue full, simultaneous load+pop → both accepted, count stays 2.
- Assert `rst` at CONV counter midpoint with `start` held high → outputs reset immediately, no strobe after release until a fresh rising `start` edge.

Source files
------------

// File: rtl/adc_stim_model.sv
// Clocked behavioural ADC front-end model: per-channel sample queues, fixed conversion latency,
// single-shot or round-robin continuous scan. Define ADC_STIM_XPROP_EN to drive X on adc_data outside the strobe.

module adc_ch_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [PW:0]           count;
  logic                  push_ok, pop_ok;

  assign full    = count == (PW+1)'(DEPTH);
  assign empty   = count == '0;
  assign head    = mem[rd_ptr];
  assign pop_ok  = pop && !empty;
  // a pop in the same cycle frees a slot, so a full queue still accepts the load
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop_ok)      count <= count + (PW+1)'(1);
      else if (!push_ok && pop_ok) count <= count - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end
endmodule

module adc_stim_model #(
  parameter int NUM_CH       = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int CONV_CYCLES  = 730,
  parameter int SAMPLE_DEPTH = 8,
  parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adc_en,
  input  logic                  start,
  input  logic                  cont,
  input  logic [CH_W-1:0]       ch_sel,
  input  logic                  load_valid,
  input  logic [CH_W-1:0]       load_ch,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  adc_eoc_n,
  output logic [DATA_WIDTH-1:0] adc_data,
  output logic [CH_W-1:0]       adc_ch,
  output logic                  busy,
  output logic                  overrun,
  output logic                  overflow,
  output logic [15:0]           conv_cnt
);
  localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(CONV_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] PAT      = DATA_WIDTH'({DATA_WIDTH{2'b01}});

  typedef enum logic [1:0] {IDLE, CONV, EOC} state_t;

  state_t                          state, state_nxt;
  logic [CNT_W-1:0]                cnt, cnt_nxt;
  logic                            start_prev, rise;
  logic                            trig, pop_req, advance;
  logic                            pat_ph;
  logic [DATA_WIDTH-1:0]           data_q;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] head;
  logic [NUM_CH-1:0]               full, empty;

  assign rise = start && !start_prev;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    adc_ch_queue #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(SAMPLE_DEPTH)) u_q (
      .clk       (clk),
      .rst       (rst),
      .push      (load_valid && load_ch == CH_W'(i)),
      .pop       (pop_req && adc_ch == CH_W'(i)),
      .push_data (load_data),
      .head      (head[i]),
      .full      (full[i]),
      .empty     (empty[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    trig      = 1'b0;
    pop_req   = 1'b0;
    advance   = 1'b0;
    if (!adc_en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: if (rise) begin
          state_nxt = CONV;
          cnt_nxt   = CNT_LOAD;
          trig      = 1'b1;
        end
        CONV: if (cnt == '0) begin
          state_nxt = EOC;
          pop_req   = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
        EOC: if (cont) begin
          state_nxt = CONV;
          cnt_nxt   = CNT_LOAD;
          advance   = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // result and strobe are registered on the edge entering EOC, so they line up with that cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_prev <= 1'b1;
      adc_eoc_n  <= 1'b1;
      data_q     <= '0;
      adc_ch     <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      overflow   <= 1'b0;
      conv_cnt   <= '0;
      pat_ph     <= 1'b0;
    end else begin
      start_prev <= start;
      busy       <= state_nxt != IDLE;
      adc_eoc_n  <= !pop_req;
      if (rise && state != IDLE) overrun <= 1'b1;
      if (load_valid && full[load_ch] && !(pop_req && load_ch == adc_ch)) overflow <= 1'b1;
      if (trig)         adc_ch <= ch_sel;
      else if (advance) adc_ch <= (adc_ch == CH_W'(NUM_CH - 1)) ? '0 : adc_ch + CH_W'(1);
      if (pop_req) begin
        conv_cnt <= conv_cnt + 16'd1;
        if (!empty[adc_ch]) begin
          data_q <= head[adc_ch];
        end else begin
          data_q <= pat_ph ? ~PAT : PAT;
          pat_ph <= ~pat_ph;
        end
      end else begin
        data_q <= '0;
      end
    end
  end

`ifdef ADC_STIM_XPROP_EN
  assign adc_data = adc_eoc_n ? {DATA_WIDTH{1'bx}} : data_q;
`else
  assign adc_data = data_q;
`endif
endmodule

// File: tb/tb_adc_stim_model.sv
// Directed bench for adc_stim_model: table of single-shot conversions plus hand sequences for
// continuous scan, overrun, queue overflow / simultaneous load+pop, and mid-conversion reset.
module tb_adc_stim_model;
  localparam int C = 730;

  logic       clk = 1'b0;
  logic       rst, adc_en, start, cont, load_valid;
  logic [1:0] ch_sel, load_ch, adc_ch;
  logic [7:0] load_data, adc_data;
  logic       adc_eoc_n, busy, overrun, overflow;
  logic [15:0] conv_cnt;

  int checks = 0;
  int errors = 0;

  adc_stim_model #(.NUM_CH(4), .DATA_WIDTH(8), .CONV_CYCLES(C), .SAMPLE_DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .adc_en     (adc_en),
    .start      (start),
    .cont       (cont),
    .ch_sel     (ch_sel),
    .load_valid (load_valid),
    .load_ch    (load_ch),
    .load_data  (load_data),
    .adc_eoc_n  (adc_eoc_n),
    .adc_data   (adc_data),
    .adc_ch     (adc_ch),
    .busy       (busy),
    .overrun    (overrun),
    .overflow   (overflow),
    .conv_cnt   (conv_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ch;
    logic [7:0]  data;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [1:0] ch, input logic [7:0] d);
    load_valid = 1'b1;
    load_ch    = ch;
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  // single-shot conversion; optionally loads sim_d into channel 0 on the strobe edge
  task automatic do_conv(input logic [1:0] ch, input logic [7:0] exp_data, input logic [15:0] exp_cnt,
                         input logic sim_load, input logic [7:0] sim_d, input string name);
    int early;
    early  = 0;
    cont   = 1'b0;
    ch_sel = ch;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    chk({name, " busy"}, 32'(busy), 32'd1);
    if (!adc_eoc_n) early++;
    for (int k = 2; k < C; k++) begin
      tick();
      if (!adc_eoc_n) early++;
    end
    chk({name, " early strobe"}, 32'(early), 32'd0);
    if (sim_load) begin
      load_valid = 1'b1;
      load_ch    = 2'd0;
      load_data  = sim_d;
    end
    tick();
    load_valid = 1'b0;
    chk({name, " eoc_n"}, 32'(adc_eoc_n), 32'd0);
    chk({name, " data"}, 32'(adc_data), 32'(exp_data));
    chk({name, " ch"}, 32'(adc_ch), 32'(ch));
    chk({name, " conv_cnt"}, 32'(conv_cnt), 32'(exp_cnt));
    tick();
    chk({name, " eoc_n after"}, 32'(adc_eoc_n), 32'd1);
    chk({name, " data after"}, 32'(adc_data), 32'd0);
    chk({name, " busy after"}, 32'(busy), 32'd0);
  endtask

  task automatic count_strobes(input int ncyc, output int strobes, output int busy_seen);
    strobes   = 0;
    busy_seen = 0;
    for (int k = 0; k < ncyc; k++) begin
      tick();
      if (!adc_eoc_n) strobes++;
      if (busy) busy_seen++;
    end
  endtask

  initial begin
    int n, s, b;
    logic [1:0] exp_ch [5];
    logic [7:0] exp_pat [5];

    vecs[0] = '{ch: 2'd2, data: 8'h55, cnt: 16'd1};
    vecs[1] = '{ch: 2'd2, data: 8'hAA, cnt: 16'd2};
    vecs[2] = '{ch: 2'd1, data: 8'h11, cnt: 16'd3};
    vecs[3] = '{ch: 2'd1, data: 8'h22, cnt: 16'd4};
    vecs[4] = '{ch: 2'd1, data: 8'h55, cnt: 16'd5};
    vecs[5] = '{ch: 2'd3, data: 8'h3C, cnt: 16'd6};
    vecs[6] = '{ch: 2'd0, data: 8'hAA, cnt: 16'd7};
    exp_ch  = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    exp_pat = '{8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55};

    rst = 1'b1; adc_en = 1'b1; start = 1'b0; cont = 1'b0; ch_sel = '0;
    load_valid = 1'b0; load_ch = '0; load_data = '0;
    repeat (2) tick();
    chk("reset eoc_n", 32'(adc_eoc_n), 32'd1);
    chk("reset data", 32'(adc_data), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset conv_cnt", 32'(conv_cnt), 32'd0);
    rst = 1'b0;
    tick();

    load(2'd1, 8'h11);
    load(2'd1, 8'h22);
    load(2'd3, 8'h3C);
    for (int i = 0; i < 7; i++)
      do_conv(vecs[i].ch, vecs[i].data, vecs[i].cnt, 1'b0, 8'h00, $sformatf("vec%0d", i));

    // continuous scan from channel 3
    cont = 1'b1; ch_sel = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      do begin tick(); n++; end while (adc_eoc_n && n < C + 5);
      chk($sformatf("cont gap%0d", i), 32'(n), (i == 0) ? 32'(C) : 32'(C + 1));
      chk($sformatf("cont ch%0d", i), 32'(adc_ch), 32'(exp_ch[i]));
      chk($sformatf("cont data%0d", i), 32'(adc_data), 32'(exp_pat[i]));
    end
    chk("cont conv_cnt", 32'(conv_cnt), 32'd12);
    repeat (3) tick();
    adc_en = 1'b0;
    tick();
    chk("disable busy", 32'(busy), 32'd0);
    count_strobes(2 * C, s, b);
    chk("disable no strobe", 32'(s), 32'd0);
    adc_en = 1'b1; cont = 1'b0;
    chk("overrun clear", 32'(overrun), 32'd0);

    // retrigger mid-conversion: ignored, flagged, timing unchanged
    ch_sel = 2'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (100) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 101;
    do begin tick(); n++; end while (adc_eoc_n && n < C + 5);
    chk("overrun timing", 32'(n), 32'(C));
    chk("overrun flag", 32'(overrun), 32'd1);
    chk("overrun data", 32'(adc_data), 32'hAA);
    chk("overrun conv_cnt", 32'(conv_cnt), 32'd13);
    count_strobes(2 * C, s, b);
    chk("overrun no extra strobe", 32'(s), 32'd0);

    // depth-2 queue overflow, then load+pop on full and on empty queue
    load(2'd0, 8'hA1);
    load(2'd0, 8'hA2);
    chk("overflow before", 32'(overflow), 32'd0);
    load(2'd0, 8'hA3);
    chk("overflow set", 32'(overflow), 32'd1);
    do_conv(2'd0, 8'hA1, 16'd14, 1'b1, 8'hA4, "full ldpop");
    do_conv(2'd0, 8'hA2, 16'd15, 1'b0, 8'h00, "q2");
    do_conv(2'd0, 8'hA4, 16'd16, 1'b0, 8'h00, "q3");
    do_conv(2'd0, 8'h55, 16'd17, 1'b1, 8'hB7, "empty ldpop");
    do_conv(2'd0, 8'hB7, 16'd18, 1'b0, 8'h00, "q5");
    chk("overflow sticky", 32'(overflow), 32'd1);

    // async reset mid-conversion with start held high
    load(2'd2, 8'h77);
    ch_sel = 2'd1; start = 1'b1;
    tick();
    repeat (C / 2) tick();
    #2 rst = 1'b1;
    #1;
    chk("async eoc_n", 32'(adc_eoc_n), 32'd1);
    chk("async data", 32'(adc_data), 32'd0);
    chk("async ch", 32'(adc_ch), 32'd0);
    chk("async busy", 32'(busy), 32'd0);
    chk("async overrun", 32'(overrun), 32'd0);
    chk("async overflow", 32'(overflow), 32'd0);
    chk("async conv_cnt", 32'(conv_cnt), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    count_strobes(C + 10, s, b);
    chk("held start strobes", 32'(s), 32'd0);
    chk("held start busy", 32'(b), 32'd0);
    start = 1'b0;
    tick();
    do_conv(2'd2, 8'h55, 16'd1, 1'b0, 8'h00, "post reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
